// File: rtl/spi_shift_engine.sv
// SPI shift engine: serialises a parallel word onto MOSI and deserialises MISO into a
// right-aligned receive word, paced by external sample/shift strobes from the SCLK generator.
module spi_shift_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = 7,
    parameter logic        IDLE_MOSI  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SPI_LOAD,
    input  logic [DATA_WIDTH-1:0] SPI_DATA_IN,
    input  logic [1:0]            SPI_DATA_LEN,
    input  logic                  SPI_BIT_ORDER,
    input  logic                  SPI_SAMPLE_EN,
    input  logic                  SPI_SHIFT_EN,
    input  logic                  SPI_ABORT,
    input  logic                  SPI_MISO,
    output logic                  SPI_MOSI,
    output logic                  SPI_BUSY,
    output logic                  SPI_DONE,
    output logic [DATA_WIDTH-1:0] SPI_RX_DATA
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic                  order_q, order_d;
    logic                  mosi_q, mosi_d;

    logic [CNT_W-1:0]      load_len;
    logic [DATA_WIDTH-1:0] load_msb;
    logic [DATA_WIDTH-1:0] rx_next;

    always_comb begin
        unique case (SPI_DATA_LEN)
            2'b00:   load_len = CNT_W'(24);
            2'b01:   load_len = CNT_W'(16);
            2'b10:   load_len = CNT_W'(8);
            default: load_len = CNT_W'(DATA_WIDTH);
        endcase
    end

    // MSB-first words are left-aligned so the outgoing bit is always the top bit;
    // bits at or above len fall off the top here.
    assign load_msb = SPI_DATA_IN << (CNT_W'(DATA_WIDTH) - load_len);

    // LSB-first fills from the top and is right-aligned when the frame completes.
    assign rx_next = order_q ? {SPI_MISO, rx_q[DATA_WIDTH-1:1]}
                             : {rx_q[DATA_WIDTH-2:0], SPI_MISO};

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        len_d     = len_q;
        rx_cnt_d  = rx_cnt_q;
        tx_cnt_d  = tx_cnt_q;
        order_d   = order_q;
        mosi_d    = mosi_q;

        unique case (state_q)
            StIdle: begin
                if (SPI_LOAD) begin
                    state_d  = StShift;
                    len_d    = load_len;
                    order_d  = SPI_BIT_ORDER;
                    rx_d     = '0;
                    rx_cnt_d = '0;
                    tx_cnt_d = CNT_W'(1);
                    if (SPI_BIT_ORDER) begin
                        mosi_d = SPI_DATA_IN[0];
                        tx_d   = SPI_DATA_IN >> 1;
                    end else begin
                        mosi_d = load_msb[DATA_WIDTH-1];
                        tx_d   = load_msb << 1;
                    end
                end
            end

            StShift: begin
                if (SPI_ABORT) begin
                    state_d = StIdle;
                    mosi_d  = IDLE_MOSI;
                end else begin
                    // tx_cnt_q counts bits already driven; once len is reached MOSI holds.
                    if (SPI_SHIFT_EN && (tx_cnt_q < len_q)) begin
                        tx_cnt_d = tx_cnt_q + CNT_W'(1);
                        if (order_q) begin
                            mosi_d = tx_q[0];
                            tx_d   = tx_q >> 1;
                        end else begin
                            mosi_d = tx_q[DATA_WIDTH-1];
                            tx_d   = tx_q << 1;
                        end
                    end
                    if (SPI_SAMPLE_EN) begin
                        rx_d     = rx_next;
                        rx_cnt_d = rx_cnt_q + CNT_W'(1);
                        if (rx_cnt_q == (len_q - CNT_W'(1))) begin
                            state_d   = StDone;
                            mosi_d    = IDLE_MOSI;
                            rx_data_d = order_q ? (rx_next >> (CNT_W'(DATA_WIDTH) - len_q))
                                                : rx_next;
                        end
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
                mosi_d  = IDLE_MOSI;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            len_q     <= '0;
            rx_cnt_q  <= '0;
            tx_cnt_q  <= '0;
            order_q   <= 1'b0;
            mosi_q    <= IDLE_MOSI;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            len_q     <= len_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_cnt_q  <= tx_cnt_d;
            order_q   <= order_d;
            mosi_q    <= mosi_d;
        end
    end

    assign SPI_MOSI    = mosi_q;
    assign SPI_BUSY    = (state_q == StShift);
    assign SPI_DONE    = (state_q == StDone);
    assign SPI_RX_DATA = rx_data_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: directed frames plus randomized frames checked
// against a bit-index reference model of the transmit and receive placement rules.
module tb_spi_shift_engine;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          SPI_LOAD;
    logic [DW-1:0] SPI_DATA_IN;
    logic [1:0]    SPI_DATA_LEN;
    logic          SPI_BIT_ORDER;
    logic          SPI_SAMPLE_EN;
    logic          SPI_SHIFT_EN;
    logic          SPI_ABORT;
    logic          SPI_MISO;
    logic          SPI_MOSI;
    logic          SPI_BUSY;
    logic          SPI_DONE;
    logic [DW-1:0] SPI_RX_DATA;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] model_rx;

    spi_shift_engine #(
        .DATA_WIDTH(DW),
        .CNT_W     (7),
        .IDLE_MOSI (1'b0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .SPI_LOAD     (SPI_LOAD),
        .SPI_DATA_IN  (SPI_DATA_IN),
        .SPI_DATA_LEN (SPI_DATA_LEN),
        .SPI_BIT_ORDER(SPI_BIT_ORDER),
        .SPI_SAMPLE_EN(SPI_SAMPLE_EN),
        .SPI_SHIFT_EN (SPI_SHIFT_EN),
        .SPI_ABORT    (SPI_ABORT),
        .SPI_MISO     (SPI_MISO),
        .SPI_MOSI     (SPI_MOSI),
        .SPI_BUSY     (SPI_BUSY),
        .SPI_DONE     (SPI_DONE),
        .SPI_RX_DATA  (SPI_RX_DATA)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int len_of(input logic [1:0] lc);
        case (lc)
            2'b00:   return 24;
            2'b01:   return 16;
            2'b10:   return 8;
            default: return DW;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        SPI_LOAD      = 1'b0;
        SPI_SAMPLE_EN = 1'b0;
        SPI_SHIFT_EN  = 1'b0;
        SPI_ABORT     = 1'b0;
    endtask

    // miso_mode: 0 loopback, 1 random, 2 held high. abort_at/rst_at: sample index, -1 = never.
    task automatic run_frame(input logic [DW-1:0] data, input logic [1:0] lc, input logic ord,
                             input bit comb, input int miso_mode, input int abort_at,
                             input int rst_at);
        int            len;
        int            pos;
        logic [DW-1:0] exp_rx;
        logic          exp_bit;
        logic          m;
        len    = len_of(lc);
        exp_rx = '0;
        SPI_DATA_IN   = data;
        SPI_DATA_LEN  = lc;
        SPI_BIT_ORDER = ord;
        SPI_LOAD      = 1'b1;
        tick();
        SPI_LOAD = 1'b0;
        // Configuration changes after the load must not disturb the frame.
        SPI_DATA_IN   = DW'($urandom);
        SPI_DATA_LEN  = 2'($urandom);
        SPI_BIT_ORDER = 1'($urandom);
        for (int i = 0; i < len; i++) begin
            exp_bit = ord ? data[i] : data[len-1-i];
            if (i == abort_at) begin
                SPI_ABORT     = 1'b1;
                SPI_SAMPLE_EN = 1'b1;
                SPI_SHIFT_EN  = 1'b1;
                tick();
                clear_strobes();
                check_eq("abort_busy", SPI_BUSY, 0);
                check_eq("abort_done", SPI_DONE, 0);
                check_eq("abort_mosi", SPI_MOSI, 0);
                check_eq("abort_rx", SPI_RX_DATA, model_rx);
                tick();
                check_eq("abort_no_done", SPI_DONE, 0);
                return;
            end
            if (i == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("rst_busy", SPI_BUSY, 0);
                check_eq("rst_done", SPI_DONE, 0);
                check_eq("rst_mosi", SPI_MOSI, 0);
                check_eq("rst_rx", SPI_RX_DATA, 0);
                model_rx = '0;
                tick();
                rst_n = 1'b1;
                tick();
                check_eq("rst_idle_busy", SPI_BUSY, 0);
                return;
            end
            check_eq("busy", SPI_BUSY, 1);
            check_eq("mosi", SPI_MOSI, exp_bit);
            if (!comb && i == len - 1) begin
                SPI_SHIFT_EN = 1'b1;
                tick();
                SPI_SHIFT_EN = 1'b0;
                check_eq("mosi_hold_last", SPI_MOSI, exp_bit);
            end
            case (miso_mode)
                0:       begin SPI_MISO = SPI_MOSI;     m = exp_bit;  end
                1:       begin SPI_MISO = 1'($urandom); m = SPI_MISO; end
                default: begin SPI_MISO = 1'b1;         m = 1'b1;     end
            endcase
            pos         = ord ? i : len - 1 - i;
            exp_rx[pos] = m;
            SPI_SAMPLE_EN = 1'b1;
            SPI_SHIFT_EN  = comb;
            SPI_LOAD      = (i == len / 2);
            tick();
            clear_strobes();
            if (!comb && i < len - 1) begin
                SPI_SHIFT_EN = 1'b1;
                tick();
                SPI_SHIFT_EN = 1'b0;
            end
        end
        check_eq("done", SPI_DONE, 1);
        check_eq("done_busy", SPI_BUSY, 0);
        check_eq("done_mosi", SPI_MOSI, 0);
        check_eq("rx", SPI_RX_DATA, exp_rx);
        model_rx = exp_rx;
        SPI_LOAD = 1'b1;
        tick();
        SPI_LOAD = 1'b0;
        check_eq("done_width", SPI_DONE, 0);
        check_eq("load_in_done_ignored", SPI_BUSY, 0);
        check_eq("rx_hold", SPI_RX_DATA, model_rx);
    endtask

    initial begin
        rst_n         = 1'b0;
        SPI_DATA_IN   = '0;
        SPI_DATA_LEN  = 2'b00;
        SPI_BIT_ORDER = 1'b0;
        SPI_MISO      = 1'b0;
        clear_strobes();
        model_rx = '0;
        #1;
        check_eq("reset_busy", SPI_BUSY, 0);
        check_eq("reset_done", SPI_DONE, 0);
        check_eq("reset_mosi", SPI_MOSI, 0);
        check_eq("reset_rx", SPI_RX_DATA, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_frame(32'h0000_00A5, 2'b10, 1'b0, 1'b0, 0, -1, -1);
        run_frame(32'h0000_1234, 2'b01, 1'b1, 1'b0, 2, -1, -1);
        run_frame(32'hDEAD_BEEF, 2'b11, 1'b0, 1'b0, 0, -1, -1);
        run_frame(32'h00AB_CDEF, 2'b00, 1'b1, 1'b0, 0, 10, -1);
        run_frame(32'h0000_0096, 2'b10, 1'b0, 1'b0, 0, -1, 3);
        run_frame(32'h0000_005A, 2'b10, 1'b0, 1'b0, 0, -1, -1);
        run_frame(32'h0000_003C, 2'b10, 1'b0, 1'b1, 0, -1, -1);

        for (int k = 0; k < 40; k++) begin
            // Strobes and abort while idle must do nothing.
            SPI_SAMPLE_EN = 1'b1;
            SPI_SHIFT_EN  = 1'b1;
            SPI_ABORT     = 1'($urandom);
            SPI_MISO      = 1'b1;
            tick();
            clear_strobes();
            check_eq("idle_strobe_busy", SPI_BUSY, 0);
            check_eq("idle_strobe_rx", SPI_RX_DATA, model_rx);
            run_frame(DW'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)),
                      (($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
